// File: rtl/sd_programm_lader.sv
// rtl/sd_programm_lader.sv - SD card program loader: length header plus payload words into RAM, CPU held in reset until done
// Optional trailing XOR checksum word: define LADER_PRUEFSUMME_EN
module sd_programm_lader #(
    parameter int unsigned MAX_WORTE     = 1024,
    parameter logic [31:0] START_ADRESSE = 32'd0,
    parameter int unsigned ACK_TIMEOUT   = 1023
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [31:0] SDAdresse,
    output logic        SDLesen,
    input  logic [31:0] SDDaten,
    input  logic        SDBusy,
    output logic [15:0] RAMAdresse,
    output logic [31:0] RAMDaten,
    output logic        RAMSchreiben,
    output logic        CPUReset,
    output logic        Fertig,
    output logic        Fehler
);
    typedef enum logic [3:0] {
        INIT_WARTEN,
        ANFORDERN,
        WARTE_ACK,
        WARTE_DATEN,
        GROESSE_PRUEFEN,
        SCHREIBEN,
`ifdef LADER_PRUEFSUMME_EN
        PRUEFEN,
`endif
        FERTIG,
        FEHLER
    } zustand_t;

    typedef enum logic [1:0] {WORT_KOPF, WORT_NUTZ, WORT_SUMME} wortArt_t;

    zustand_t    zustand;
    wortArt_t    wortArt;
    logic [31:0] gelesen;
    logic [31:0] rest;
    logic [31:0] timer;
`ifdef LADER_PRUEFSUMME_EN
    logic [31:0] xorSumme;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand      <= INIT_WARTEN;
            wortArt      <= WORT_KOPF;
            gelesen      <= '0;
            rest         <= '0;
            timer        <= '0;
            SDAdresse    <= START_ADRESSE;
            SDLesen      <= 1'b0;
            RAMAdresse   <= '0;
            RAMDaten     <= '0;
            RAMSchreiben <= 1'b0;
            CPUReset     <= 1'b1;
            Fertig       <= 1'b0;
            Fehler       <= 1'b0;
`ifdef LADER_PRUEFSUMME_EN
            xorSumme     <= '0;
`endif
        end else begin
            SDLesen      <= 1'b0;
            RAMSchreiben <= 1'b0;
            case (zustand)
                INIT_WARTEN: begin
                    if (!SDBusy) begin
                        SDAdresse <= START_ADRESSE;
                        wortArt   <= WORT_KOPF;
                        SDLesen   <= 1'b1;
                        zustand   <= ANFORDERN;
                    end
                end
                // SDLesen is high exactly while in ANFORDERN
                ANFORDERN: begin
                    timer   <= '0;
                    zustand <= WARTE_ACK;
                end
                WARTE_ACK: begin
                    if (SDBusy) begin
                        zustand <= WARTE_DATEN;
                    end else if (timer >= ACK_TIMEOUT - 1) begin
                        Fehler  <= 1'b1;
                        zustand <= FEHLER;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                WARTE_DATEN: begin
                    if (!SDBusy) begin
                        gelesen <= SDDaten;
                        case (wortArt)
                            WORT_KOPF: zustand <= GROESSE_PRUEFEN;
                            WORT_NUTZ: begin
                                RAMDaten     <= SDDaten;
                                RAMSchreiben <= 1'b1;
                                zustand      <= SCHREIBEN;
`ifdef LADER_PRUEFSUMME_EN
                                xorSumme     <= xorSumme ^ SDDaten;
`endif
                            end
`ifdef LADER_PRUEFSUMME_EN
                            default: zustand <= PRUEFEN;
`else
                            default: begin
                                Fehler  <= 1'b1;
                                zustand <= FEHLER;
                            end
`endif
                        endcase
                    end
                end
                GROESSE_PRUEFEN: begin
                    if (gelesen > MAX_WORTE) begin
                        Fehler  <= 1'b1;
                        zustand <= FEHLER;
                    end else if (gelesen == 32'd0) begin
`ifdef LADER_PRUEFSUMME_EN
                        SDAdresse <= SDAdresse + 32'd1;
                        wortArt   <= WORT_SUMME;
                        SDLesen   <= 1'b1;
                        zustand   <= ANFORDERN;
`else
                        Fertig    <= 1'b1;
                        CPUReset  <= 1'b0;
                        zustand   <= FERTIG;
`endif
                    end else begin
                        rest      <= gelesen;
                        SDAdresse <= SDAdresse + 32'd1;
                        wortArt   <= WORT_NUTZ;
                        SDLesen   <= 1'b1;
                        zustand   <= ANFORDERN;
                    end
                end
                SCHREIBEN: begin
                    rest       <= rest - 32'd1;
                    RAMAdresse <= RAMAdresse + 16'd1;
                    SDAdresse  <= SDAdresse + 32'd1;
                    if (rest == 32'd1) begin
`ifdef LADER_PRUEFSUMME_EN
                        wortArt  <= WORT_SUMME;
                        SDLesen  <= 1'b1;
                        zustand  <= ANFORDERN;
`else
                        Fertig   <= 1'b1;
                        CPUReset <= 1'b0;
                        zustand  <= FERTIG;
`endif
                    end else begin
                        SDLesen <= 1'b1;
                        zustand <= ANFORDERN;
                    end
                end
`ifdef LADER_PRUEFSUMME_EN
                PRUEFEN: begin
                    if (gelesen == xorSumme) begin
                        Fertig   <= 1'b1;
                        CPUReset <= 1'b0;
                        zustand  <= FERTIG;
                    end else begin
                        Fehler  <= 1'b1;
                        zustand <= FEHLER;
                    end
                end
`endif
                FERTIG:  zustand <= FERTIG;
                FEHLER:  zustand <= FEHLER;
                default: zustand <= INIT_WARTEN;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_programm_lader.sv
// tb/tb_sd_programm_lader.sv - self-checking bench for sd_programm_lader with a randomized SD card model
module tb_sd_programm_lader;
    localparam int START   = 4;
    localparam int TIMEOUT = 20;
    localparam int MAXW    = 1024;

    logic        Clock;
    logic        Reset;
    logic [31:0] SDAdresse;
    logic        SDLesen;
    logic [31:0] SDDaten;
    logic        SDBusy;
    logic [15:0] RAMAdresse;
    logic [31:0] RAMDaten;
    logic        RAMSchreiben;
    logic        CPUReset;
    logic        Fertig;
    logic        Fehler;

    sd_programm_lader #(
        .MAX_WORTE(MAXW), .START_ADRESSE(32'(START)), .ACK_TIMEOUT(TIMEOUT)
    ) dut (
        .Clock(Clock), .Reset(Reset), .SDAdresse(SDAdresse), .SDLesen(SDLesen),
        .SDDaten(SDDaten), .SDBusy(SDBusy), .RAMAdresse(RAMAdresse), .RAMDaten(RAMDaten),
        .RAMSchreiben(RAMSchreiben), .CPUReset(CPUReset), .Fertig(Fertig), .Fehler(Fehler)
    );

    initial Clock = 1'b0;
    initial forever #20 Clock = ~Clock;

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] sdMem [64];
    logic [31:0] ramBild [1024];
    logic [31:0] pay [16];

    int   lesenAnzahl = 0, lastLesenCyc = 0, protoFehler = 0, adrFehler = 0;
    int   schreibAnzahl = 0, letzteSchreibCyc = 0, fertigCyc = -1, fehlerCyc = -1;
    int   sdInit = 0, stummAb = 0, lat = 0;
    logic [31:0] ersteAdresse = '0;
    logic [5:0]  adr;
    bit   vorherLesen = 1'b0;
    bit   sdIdle = 1'b1;

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    // SD card: busy while initialising, then answers each request after a random latency
    initial begin
        SDBusy  = 1'b1;
        SDDaten = '0;
        forever begin
            @(negedge Clock);
            if (SDLesen) begin
                lesenAnzahl++;
                lastLesenCyc = cyc;
                if (lesenAnzahl == 1) ersteAdresse = SDAdresse;
                if (SDBusy || vorherLesen) protoFehler++;
            end
            vorherLesen = SDLesen;
            if (sdInit > 0) begin
                SDBusy = 1'b1;
                sdInit--;
            end else if (SDLesen && (stummAb == 0 || lesenAnzahl < stummAb)) begin
                adr     = SDAdresse[5:0];
                lat     = $urandom_range(2, 5);
                sdIdle  = 1'b0;
                SDBusy  = 1'b1;
                SDDaten = $urandom;
                repeat (lat) begin
                    @(negedge Clock);
                    if (SDLesen) protoFehler++;
                    vorherLesen = SDLesen;
                end
                SDDaten = sdMem[adr];
                SDBusy  = 1'b0;
                sdIdle  = 1'b1;
            end else begin
                SDBusy = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge Clock);
        if (RAMSchreiben) begin
            if (32'(RAMAdresse) != 32'(schreibAnzahl)) adrFehler++;
            ramBild[RAMAdresse[9:0]] = RAMDaten;
            schreibAnzahl++;
            letzteSchreibCyc = cyc;
        end
        if (Fertig && fertigCyc < 0) fertigCyc = cyc;
        if (Fehler && fehlerCyc < 0) fehlerCyc = cyc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut(input bit pruefen);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        for (int i = 0; i < 50 && !sdIdle; i++) @(negedge Clock);
        if (pruefen) begin
            chk("rst_SDLesen", 32'(SDLesen), 32'd0);
            chk("rst_SDAdresse", SDAdresse, 32'(START));
            chk("rst_RAMSchreiben", 32'(RAMSchreiben), 32'd0);
            chk("rst_RAMAdresse", 32'(RAMAdresse), 32'd0);
            chk("rst_RAMDaten", RAMDaten, 32'd0);
            chk("rst_Fertig", 32'(Fertig), 32'd0);
            chk("rst_Fehler", 32'(Fehler), 32'd0);
            chk("rst_CPUReset", 32'(CPUReset), 32'd1);
        end
        lesenAnzahl = 0; protoFehler = 0; adrFehler = 0; schreibAnzahl = 0;
        fertigCyc = -1; fehlerCyc = -1; ersteAdresse = '0;
        for (int i = 0; i < 16; i++) ramBild[i] = 32'hDEADBEEF;
        sdInit = $urandom_range(1, 6);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Outcome derived from the loader's rules: requests needed, words written, accepted or not
    function automatic void erwartung(input int n, input logic [31:0] cks, input int stumm,
                                      output bit eFertig, output int eSchreib, output int eLesen);
        logic [31:0] x = '0;
        int gesamt;
        for (int i = 0; i < n && i < 16; i++) x ^= pay[i];
        if (n > MAXW) begin
            eFertig = 1'b0; eSchreib = 0; eLesen = 1;
            return;
        end
        gesamt = 1 + n;
        eFertig = 1'b1;
`ifdef LADER_PRUEFSUMME_EN
        gesamt++;
        eFertig = (cks == x);
`endif
        eSchreib = n;
        eLesen = gesamt;
        if (stumm > 0 && stumm <= gesamt) begin
            eFertig = 1'b0;
            eLesen = stumm;
            eSchreib = (stumm - 2 < 0) ? 0 : ((stumm - 2 > n) ? n : stumm - 2);
        end
    endfunction

    task automatic laden(input int n, input logic [31:0] cks);
        sdMem[START] = 32'(n);
        for (int i = 0; i < 16; i++) sdMem[START + 1 + i] = pay[i];
        if (n <= 16) sdMem[START + 1 + n] = cks;
    endtask

    task automatic waitEnde();
        for (int i = 0; i < 3000 && !(Fertig || Fehler); i++) @(negedge Clock);
        chk("ende_erreicht", 32'(Fertig | Fehler), 32'd1);
        repeat (6) @(negedge Clock);
    endtask

    task automatic lauf(input string name, input int n, input logic [31:0] cks, input int stumm,
                        input bit rstPruefen);
        bit eFertig;
        int eSchreib, eLesen;
        laden(n, cks);
        stummAb = stumm;
        resetDut(rstPruefen);
        waitEnde();
        erwartung(n, cks, stumm, eFertig, eSchreib, eLesen);
        chk({name, "_Fertig"}, 32'(Fertig), 32'(eFertig));
        chk({name, "_Fehler"}, 32'(Fehler), 32'(!eFertig));
        chk({name, "_CPUReset"}, 32'(CPUReset), 32'(!eFertig));
        chk({name, "_schreib"}, 32'(schreibAnzahl), 32'(eSchreib));
        chk({name, "_lesen"}, 32'(lesenAnzahl), 32'(eLesen));
        chk({name, "_ersteAdr"}, ersteAdresse, 32'(START));
        chk({name, "_proto"}, 32'(protoFehler + adrFehler), 32'd0);
        for (int k = 0; k < eSchreib; k++)
            chk($sformatf("%s_ram%0d", name, k), ramBild[k], pay[k]);
`ifndef LADER_PRUEFSUMME_EN
        if (eFertig && eSchreib > 0)
            chk({name, "_fertigTakt"}, 32'(fertigCyc), 32'(letzteSchreibCyc + 1));
`endif
        if (!eFertig && stumm > 0 && eLesen == stumm)
            chk({name, "_timeoutTakt"}, 32'(fehlerCyc), 32'(lastLesenCyc + 1 + TIMEOUT));
    endtask

    function automatic logic [31:0] xorVon(input int n);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) x ^= pay[i];
        return x;
    endfunction

    initial begin
        int n;
        Reset = 1'b1;
        for (int i = 0; i < 64; i++) sdMem[i] = '0;
        for (int i = 0; i < 16; i++) pay[i] = '0;
        repeat (2) @(negedge Clock);

        pay[0] = 32'h11; pay[1] = 32'h22; pay[2] = 32'h33;
        lauf("drei", 3, xorVon(3), 0, 1'b1);
        lauf("null", 0, 32'd0, 0, 1'b0);
        lauf("gross", 1025, 32'd0, 0, 1'b0);
        lauf("timeout", 3, xorVon(3), 2, 1'b0);

        for (int i = 0; i < 5; i++) pay[i] = $urandom;
        laden(5, xorVon(5));
        stummAb = 0;
        resetDut(1'b0);
        for (int i = 0; i < 3000 && schreibAnzahl < 2; i++) @(negedge Clock);
        chk("mitte_zwei", 32'(schreibAnzahl), 32'd2);
        lauf("neustart", 5, xorVon(5), 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < 16; i++) pay[i] = $urandom;
            lauf($sformatf("zufall%0d", r), n, xorVon(n), 0, 1'b0);
        end
        lauf("zuGross", 1025 + $urandom_range(0, 5000), 32'd0, 0, 1'b0);

`ifdef LADER_PRUEFSUMME_EN
        pay[0] = 32'h0F; pay[1] = 32'hF0;
        lauf("summeOk", 2, 32'hFF, 0, 1'b0);
        lauf("summeFalsch", 2, 32'hFE, 0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
